// File: rtl/xosera_pkg.sv
// Shared Xosera definitions: copper opcodes, WAIT/SKIP flag bits and copper FSM states.
package xosera_pkg;

    localparam logic [3:0] OP_WAIT  = 4'h0;
    localparam logic [3:0] OP_SKIP  = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_MOVEP = 4'hB;

    localparam int FLAG_IGN_V = 0;
    localparam int FLAG_IGN_H = 1;

    // WAIT ignoring both V and H means "wait for next frame".
    localparam logic [3:0] FLAGS_NEXTF = 4'b0011;

    typedef enum logic [2:0] {
        COP_IDLE,
        COP_FETCH0,
        COP_FETCH1,
        COP_LATCH,
        COP_EXEC,
        COP_WAITPOS,
        COP_WRITE,
        COP_HALT
    } cop_state_t;

endpackage

// File: rtl/copper_engine.sv
// Copper program fetch/execute engine: 2-word instructions, beam-position waits, palette writes.
// Optional build macro COPPER_TRACE_EN adds the cop_pc_o / cop_exec_o / cop_icount_o trace outputs.
module copper_engine
    import xosera_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int PAL_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  cop_en_i,
    input  logic                  end_of_frame_i,
    input  logic [10:0]           h_count_i,
    input  logic [10:0]           v_count_i,
    output logic                  rd_en_o,
    output logic [ADDR_W-1:0]     rd_address_o,
    input  logic [15:0]           rd_data_i,
`ifdef COPPER_TRACE_EN
    output logic [ADDR_W-1:0]     cop_pc_o,
    output logic                  cop_exec_o,
    output logic [15:0]           cop_icount_o,
`endif
    output logic                  pal_wr_en_o,
    output logic [PAL_ADDR_W-1:0] pal_addr_o,
    output logic [15:0]           pal_data_o,
    input  logic                  pal_ack_i
);

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] PC_FOUR = ADDR_W'(4);

    cop_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       w0;
    logic [15:0]       w1;
    logic              reached;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] jmp_target;
    logic              unused_bits;

    function automatic logic pos_reached(input logic [10:0] v_cnt, input logic [10:0] h_cnt,
                                         input logic [15:0] i_w0, input logic [15:0] i_w1);
        logic [3:0] flags;
        flags = i_w1[3:0];
        return (flags[FLAG_IGN_V] | (v_cnt >= i_w0[10:0])) &
               (flags[FLAG_IGN_H] | (h_cnt >= i_w1[14:4]));
    endfunction

    assign reached     = pos_reached(v_count_i, h_count_i, w0, w1);
    assign opcode      = w0[15:12];
    assign jmp_target  = ADDR_W'({w0[10:1], 1'b0});
    assign unused_bits = ^{w0[11], w1[15]};

    // Pipelined instruction fetch: memory answers one cycle after the address is presented.
    always_ff @(posedge clk or posedge reset_i) begin
        // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset_i) begin
            state <= COP_IDLE;
            pc    <= '0;
            w0    <= '0;
            w1    <= '0;
        end else if (!cop_en_i) begin
            state <= COP_IDLE;
        end else if (end_of_frame_i) begin
            pc    <= '0;
            state <= COP_FETCH0;
        end else begin
            case (state)
                COP_FETCH0: state <= COP_FETCH1;
                COP_FETCH1: begin
                    w0    <= rd_data_i;
                    state <= COP_LATCH;
                end
                COP_LATCH: begin
                    w1    <= rd_data_i;
                    state <= COP_EXEC;
                end
                COP_EXEC: begin
                    case (opcode)
                        OP_WAIT: begin
                            if (w1[3:0] == FLAGS_NEXTF) begin
                                state <= COP_HALT;
                            end else if (reached) begin
                                pc    <= pc + PC_TWO;
                                state <= COP_FETCH0;
                            end else begin
                                state <= COP_WAITPOS;
                            end
                        end
                        OP_SKIP: begin
                            pc    <= pc + (reached ? PC_FOUR : PC_TWO);
                            state <= COP_FETCH0;
                        end
                        OP_JMP: begin
                            pc    <= jmp_target;
                            state <= COP_FETCH0;
                        end
                        OP_MOVEP: state <= COP_WRITE;
                        default: begin
                            pc    <= pc + PC_TWO;
                            state <= COP_FETCH0;
                        end
                    endcase
                end
                COP_WAITPOS: begin
                    if (reached) begin
                        pc    <= pc + PC_TWO;
                        state <= COP_FETCH0;
                    end
                end
                COP_WRITE: begin
                    if (pal_ack_i) begin
                        pc    <= pc + PC_TWO;
                        state <= COP_FETCH0;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Outputs decode straight from state so a disable, frame wrap or reset drops them on the same edge.
    assign rd_en_o      = (state == COP_FETCH0) || (state == COP_FETCH1);
    assign rd_address_o = (state == COP_FETCH0) ? pc :
                          (state == COP_FETCH1) ? pc + PC_ONE : '0;
    assign pal_wr_en_o  = (state == COP_WRITE);
    assign pal_addr_o   = pal_wr_en_o ? PAL_ADDR_W'(w0[7:0]) : '0;
    assign pal_data_o   = pal_wr_en_o ? w1 : '0;

`ifdef COPPER_TRACE_EN
    assign cop_exec_o = (state == COP_EXEC);
    assign cop_pc_o   = cop_exec_o ? pc : '0;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cop_icount_o <= '0;
        end else if (end_of_frame_i) begin
            cop_icount_o <= '0;
        end else if (cop_exec_o && (cop_icount_o != 16'hFFFF)) begin
            cop_icount_o <= cop_icount_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_copper_engine.sv
// Directed testbench for copper_engine: table of single-instruction vectors plus multi-cycle sequences.
module tb_copper_engine;

    localparam logic [11:0] NONE = 12'hFFF;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cop_en_i;
    logic        end_of_frame_i;
    logic [10:0] h_count_i;
    logic [10:0] v_count_i;
    logic        rd_en_o;
    logic [10:0] rd_address_o;
    logic [15:0] rd_data_i = '0;
    logic        pal_wr_en_o;
    logic [7:0]  pal_addr_o;
    logic [15:0] pal_data_o;
    logic        pal_ack_i;
`ifdef COPPER_TRACE_EN
    logic [10:0] cop_pc_o;
    logic        cop_exec_o;
    logic [15:0] cop_icount_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [2048];
    logic [10:0] got [8];
    int          n_got;

    copper_engine #(.ADDR_W(11), .PAL_ADDR_W(8)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .cop_en_i       (cop_en_i),
        .end_of_frame_i (end_of_frame_i),
        .h_count_i      (h_count_i),
        .v_count_i      (v_count_i),
        .rd_en_o        (rd_en_o),
        .rd_address_o   (rd_address_o),
        .rd_data_i      (rd_data_i),
`ifdef COPPER_TRACE_EN
        .cop_pc_o       (cop_pc_o),
        .cop_exec_o     (cop_exec_o),
        .cop_icount_o   (cop_icount_o),
`endif
        .pal_wr_en_o    (pal_wr_en_o),
        .pal_addr_o     (pal_addr_o),
        .pal_data_o     (pal_data_o),
        .pal_ack_i      (pal_ack_i)
    );

    always #5 clk = ~clk;

    // Registered-read copper BRAM model.
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem[rd_address_o];
    end

    typedef struct {
        string       name;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [10:0] v;
        logic [10:0] h;
        logic [11:0] exp_next;
        logic        exp_pal;
        logic [7:0]  exp_paddr;
        logic [15:0] exp_pdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every instruction slot becomes NEXTF (WAIT, flags 3) unless overwritten.
    task automatic fill_halt();
        for (int i = 0; i < 2048; i++) mem[i] = i[0] ? 16'h0003 : 16'h0000;
    endtask

    task automatic pulse_eof();
        end_of_frame_i = 1'b1;
        cyc();
        end_of_frame_i = 1'b0;
    endtask

    task automatic collect(input int want);
        n_got = 0;
        for (int i = 0; i < 40 && n_got < want; i++) begin
            if (rd_en_o) begin
                got[n_got] = rd_address_o;
                n_got++;
            end
            cyc();
        end
    endtask

    task automatic count_reads(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (rd_en_o) n++;
            cyc();
        end
    endtask

    task automatic wait_pal(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pal_wr_en_o) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          nreads;
        logic [11:0] third;
        bit          saw_pal;
        logic [7:0]  paddr;
        logic [15:0] pdata;
        fill_halt();
        mem[0] = v.w0;
        mem[1] = v.w1;
        v_count_i = v.v;
        h_count_i = v.h;
        pal_ack_i = 1'b1;
        pulse_eof();
        nreads  = 0;
        third   = NONE;
        saw_pal = 1'b0;
        paddr   = '0;
        pdata   = '0;
        for (int k = 0; k < 14; k++) begin
            if (rd_en_o) begin
                if (nreads == 2) third = {1'b0, rd_address_o};
                nreads++;
            end
            if (pal_wr_en_o && !saw_pal) begin
                saw_pal = 1'b1;
                paddr   = pal_addr_o;
                pdata   = pal_data_o;
            end
            cyc();
        end
        check({v.name, "_next"}, third, v.exp_next);
        check({v.name, "_pal"}, saw_pal, v.exp_pal);
        if (v.exp_pal) begin
            check({v.name, "_paddr"}, paddr, v.exp_paddr);
            check({v.name, "_pdata"}, pdata, v.exp_pdata);
        end
    endtask

    initial begin
        int          n;
        int          first;
        int          pal_cnt;
        int          rd_mid;
        int          rd_late;
        bit          ok;
        logic [10:0] exp_jmp [8];
        logic [10:0] exp_skp [6];

        reset_i        = 1'b1;
        cop_en_i       = 1'b0;
        end_of_frame_i = 1'b0;
        h_count_i      = '0;
        v_count_i      = '0;
        pal_ack_i      = 1'b0;
        fill_halt();
        #2;
        check("rst_rd_en", rd_en_o, 0);
        check("rst_rd_addr", rd_address_o, 0);
        check("rst_pal_wr", pal_wr_en_o, 0);
        check("rst_pal_addr", pal_addr_o, 0);
        check("rst_pal_data", pal_data_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        cyc();
        cop_en_i = 1'b1;

        vecs[0]  = '{"wait_v_below",   16'h00A0, 16'h0000, 11'd100,  11'd0,   NONE,   1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{"wait_v_equal",   16'h00A0, 16'h0000, 11'd160,  11'd0,   12'd2,  1'b0, 8'h00, 16'h0000};
        vecs[2]  = '{"wait_h_below",   16'h0000, 16'h1400, 11'd5,    11'd319, NONE,   1'b0, 8'h00, 16'h0000};
        vecs[3]  = '{"wait_h_equal",   16'h0000, 16'h1400, 11'd5,    11'd320, 12'd2,  1'b0, 8'h00, 16'h0000};
        vecs[4]  = '{"wait_ign_v",     16'h07FF, 16'h0001, 11'd0,    11'd0,   12'd2,  1'b0, 8'h00, 16'h0000};
        vecs[5]  = '{"wait_v_max",     16'h07FF, 16'h0000, 11'd2046, 11'd0,   NONE,   1'b0, 8'h00, 16'h0000};
        vecs[6]  = '{"nextf",          16'h0000, 16'h0003, 11'd500,  11'd500, NONE,   1'b0, 8'h00, 16'h0000};
        vecs[7]  = '{"skip_not",       16'h2140, 16'h0002, 11'd100,  11'd0,   12'd2,  1'b0, 8'h00, 16'h0000};
        vecs[8]  = '{"skip_reached",   16'h2140, 16'h0002, 11'd320,  11'd0,   12'd4,  1'b0, 8'h00, 16'h0000};
        vecs[9]  = '{"jmp_odd",        16'h4011, 16'h0000, 11'd0,    11'd0,   12'd16, 1'b0, 8'h00, 16'h0000};
        vecs[10] = '{"movep",          16'hB055, 16'h0F00, 11'd0,    11'd0,   12'd2,  1'b1, 8'h55, 16'h0F00};
        vecs[11] = '{"nop",            16'h7000, 16'hFFFF, 11'd0,    11'd0,   12'd2,  1'b0, 8'h00, 16'h0000};
        vecs[12] = '{"wait_vh_h_low",  16'h00A0, 16'h1400, 11'd200,  11'd100, NONE,   1'b0, 8'h00, 16'h0000};

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Banded program: WAIT V=160; MOVEP 0,0x0F00; NEXTF.
        fill_halt();
        mem[0] = 16'h00A0; mem[1] = 16'h0000;
        mem[2] = 16'hB000; mem[3] = 16'h0F00;
        v_count_i = 11'd150;
        h_count_i = 11'd0;
        pal_ack_i = 1'b1;
        pulse_eof();
        pal_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (pal_wr_en_o) pal_cnt++;
            cyc();
        end
        check("band_no_early_write", pal_cnt, 0);
        v_count_i = 11'd160;
        first = 0; pal_cnt = 0; rd_mid = 0; rd_late = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (pal_wr_en_o) begin
                pal_cnt++;
                if (first == 0) begin
                    first = i;
                    check("band_pal_addr", pal_addr_o, 8'h00);
                    check("band_pal_data", pal_data_o, 16'h0F00);
                end
            end
            if (rd_en_o && (i == 6 || i == 7)) rd_mid++;
            if (rd_en_o && i >= 8) rd_late++;
        end
        check("band_write_cycle", first, 5);
        check("band_write_count", pal_cnt, 1);
        check("band_nextf_fetch", rd_mid, 2);
        check("band_halt_no_reads", rd_late, 0);
        pulse_eof();
        check("band_eof_rd_en", rd_en_o, 1);
        check("band_eof_rd_addr", rd_address_o, 0);

        // JMP 2046 then JMP 0 at 2046: endless two-instruction loop.
        fill_halt();
        mem[0] = 16'h47FE;    mem[1] = 16'h0000;
        mem[2046] = 16'h4000; mem[2047] = 16'h0000;
        exp_jmp = '{11'd0, 11'd1, 11'd2046, 11'd2047, 11'd0, 11'd1, 11'd2046, 11'd2047};
        pulse_eof();
        collect(8);
        check("jmp_loop_nreads", n_got, 8);
        for (int i = 0; i < 8; i++) check($sformatf("jmp_loop_addr%0d", i), got[i], exp_jmp[i]);

        // SKIP reached at 2046 wraps pc to 2.
        mem[2046] = 16'h2000; mem[2047] = 16'h0003;
        exp_skp = '{11'd0, 11'd1, 11'd2046, 11'd2047, 11'd2, 11'd3};
        pulse_eof();
        collect(6);
        check("skip_wrap_nreads", n_got, 6);
        for (int i = 0; i < 6; i++) check($sformatf("skip_wrap_addr%0d", i), got[i], exp_skp[i]);

        // MOVEP with ack delayed three cycles.
        fill_halt();
        mem[0] = 16'hB0AA; mem[1] = 16'h1234;
        pal_ack_i = 1'b0;
        pulse_eof();
        wait_pal(ok);
        check("slow_ack_write_seen", ok, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("slow_ack_wr_en%0d", k), pal_wr_en_o, 1);
            check($sformatf("slow_ack_addr%0d", k), pal_addr_o, 8'hAA);
            check($sformatf("slow_ack_data%0d", k), pal_data_o, 16'h1234);
            if (k == 3) pal_ack_i = 1'b1;
            cyc();
        end
        pal_ack_i = 1'b0;
        check("slow_ack_wr_drop", pal_wr_en_o, 0);
        check("slow_ack_fetch_en", rd_en_o, 1);
        check("slow_ack_fetch_addr", rd_address_o, 2);

        // Frame wrap abandons a pending palette write.
        pulse_eof();
        wait_pal(ok);
        check("eof_write_seen", ok, 1);
        cyc();
        cyc();
        end_of_frame_i = 1'b1;
        cyc();
        end_of_frame_i = 1'b0;
        check("eof_write_dropped", pal_wr_en_o, 0);
        check("eof_refetch_en", rd_en_o, 1);
        check("eof_refetch_addr", rd_address_o, 0);
        cyc();
        check("eof_refetch_addr1", rd_address_o, 1);

        // Asynchronous reset during FETCH1.
        fill_halt();
        pulse_eof();
        cyc();
        check("pre_reset_fetch1_addr", rd_address_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check("async_rst_rd_en", rd_en_o, 0);
        check("async_rst_rd_addr", rd_address_o, 0);
        check("async_rst_pal_wr", pal_wr_en_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        cyc();
        count_reads(6, n);
        check("post_reset_idle_reads", n, 0);

        // Disable during WAITPOS returns to IDLE and stays there.
        mem[0] = 16'h07FF; mem[1] = 16'h0000;
        v_count_i = 11'd0;
        pulse_eof();
        repeat (6) cyc();
        count_reads(1, n);
        check("waitpos_no_reads", n, 0);
        cop_en_i = 1'b0;
        cyc();
        cop_en_i  = 1'b1;
        v_count_i = 11'd2047;
        count_reads(8, n);
        check("disable_to_idle_reads", n, 0);
        cop_en_i = 1'b0;
        pulse_eof();
        count_reads(4, n);
        check("disabled_eof_reads", n, 0);
        cop_en_i = 1'b1;
        pulse_eof();
        check("reenable_rd_en", rd_en_o, 1);
        check("reenable_rd_addr", rd_address_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
